mist1032isa_uart_rx_controller: RTL and testbench

MIST1032ISA_UART_RX_CONTROLLER -- requirements
Module: mist1032isa_uart_rx_controller

---
 rtl/mist1032isa_uart_rx_controller.sv | 136 +++++++++++++
 tb/tb_mist1032isa_uart_rx_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mist1032isa_uart_rx_controller.sv
// UART receive-side buffer: 16-entry byte FIFO with overflow tracking, an idle
// character-timeout FSM and a registered interrupt request.
module mist1032isa_uart_rx_controller #(
    parameter int FIFO_DEPTH_N = 4
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET,
    input  logic                    iENABLE,
    input  logic                    iRX_VALID,
    input  logic [7:0]              iRX_DATA,
    input  logic                    iRD_REQ,
    output logic                    oRD_VALID,
    output logic [7:0]              oRD_DATA,
    output logic [FIFO_DEPTH_N:0]   oCOUNT,
    output logic                    oEMPTY,
    output logic                    oFULL,
    output logic                    oOVERFLOW,
    input  logic                    iOVERFLOW_CLR,
    input  logic [FIFO_DEPTH_N:0]   iIRQ_THRESH,
    input  logic [19:0]             iTIMEOUT_COUNT,
    output logic                    oTIMEOUT,
    output logic                    oIRQ
);

    localparam int DEPTH = 1 << FIFO_DEPTH_N;
    localparam int PW    = FIFO_DEPTH_N + 1;

    typedef enum logic [1:0] {
        TO_IDLE,
        TO_COUNT,
        TO_EXPIRED
    } to_state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          overflow_q, overflow_d;
    logic          irq_q, irq_d;
    to_state_e     state_q, state_d;
    logic [19:0]   tcnt_q, tcnt_d;

    logic [PW-1:0] count, count_next;
    logic          empty, full, do_push, do_pop, drop, timeout;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        empty      = (count == '0);
        full       = (count == PW'(DEPTH));
        do_pop     = iRD_REQ && !empty;
        do_push    = iRX_VALID && iENABLE && (!full || do_pop);
        drop       = iRX_VALID && iENABLE && full && !do_pop;
        wr_ptr_d   = wr_ptr_q + PW'(do_push);
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        count_next = wr_ptr_d - rd_ptr_d;
        rd_valid_d = do_pop;
        rd_data_d  = do_pop ? mem_q[rd_ptr_q[FIFO_DEPTH_N-1:0]] : rd_data_q;
        // A dropped byte wins over a clear arriving in the same cycle.
        overflow_d = drop ? 1'b1 : (iOVERFLOW_CLR ? 1'b0 : overflow_q);
        timeout    = (state_q == TO_EXPIRED);
        irq_d      = ((iIRQ_THRESH != '0) && (count >= iIRQ_THRESH)) || timeout;
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            TO_IDLE: begin
                tcnt_d = '0;
                if (!empty && (iTIMEOUT_COUNT != '0)) state_d = TO_COUNT;
            end
            TO_COUNT: begin
                if ((count_next == '0) || (iTIMEOUT_COUNT == '0)) begin
                    state_d = TO_IDLE;
                    tcnt_d  = '0;
                end else if (do_push || do_pop) begin
                    tcnt_d = '0;
                end else if (tcnt_q == iTIMEOUT_COUNT - 20'd1) begin
                    state_d = TO_EXPIRED;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 20'd1;
                end
            end
            TO_EXPIRED: begin
                tcnt_d = '0;
                if (do_pop) state_d = (count_next != '0) ? TO_COUNT : TO_IDLE;
            end
            default: begin
                state_d = TO_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            state_q    <= TO_IDLE;
            tcnt_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge iCLOCK) begin
        if (do_push) mem_q[wr_ptr_q[FIFO_DEPTH_N-1:0]] <= iRX_DATA;
    end

    assign oRD_VALID = rd_valid_q;
    assign oRD_DATA  = rd_data_q;
    assign oCOUNT    = count;
    assign oEMPTY    = empty;
    assign oFULL     = full;
    assign oOVERFLOW = overflow_q;
    assign oTIMEOUT  = timeout;
    assign oIRQ      = irq_q;

endmodule

// File: tb/tb_mist1032isa_uart_rx_controller.sv
// Self-checking bench: queue-based FIFO model acting as read scoreboard, plus
// directed checks for reset, overflow, timeout and interrupt timing.
module tb_mist1032isa_uart_rx_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, rx_vld, rd_req, ovf_clr;
    logic [7:0]  rx_data;
    logic [4:0]  thresh;
    logic [19:0] tmo_cnt;
    logic        rd_valid, empty, full, ovf, tmo, irq;
    logic [7:0]  rd_data;
    logic [4:0]  count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [7:0] model_q[$];
    logic [7:0] rd_expect[$];
    bit         model_ovf;

    always #5 clk = ~clk;

    mist1032isa_uart_rx_controller #(.FIFO_DEPTH_N(4)) dut (
        .iCLOCK(clk), .iRESET(rst), .iENABLE(en),
        .iRX_VALID(rx_vld), .iRX_DATA(rx_data), .iRD_REQ(rd_req),
        .oRD_VALID(rd_valid), .oRD_DATA(rd_data), .oCOUNT(count),
        .oEMPTY(empty), .oFULL(full), .oOVERFLOW(ovf),
        .iOVERFLOW_CLR(ovf_clr), .iIRQ_THRESH(thresh),
        .iTIMEOUT_COUNT(tmo_cnt), .oTIMEOUT(tmo), .oIRQ(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference FIFO: accepted reads move the head byte into the scoreboard.
    always @(posedge clk or posedge rst) begin
        bit pop_m, push_m, drop_m;
        if (rst) begin
            model_q.delete();
            rd_expect.delete();
            model_ovf = 1'b0;
        end else begin
            pop_m  = rd_req && (model_q.size() > 0);
            push_m = rx_vld && en && ((model_q.size() < 16) || pop_m);
            drop_m = rx_vld && en && (model_q.size() == 16) && !pop_m;
            if (pop_m) rd_expect.push_back(model_q.pop_front());
            if (push_m) model_q.push_back(rx_data);
            if (drop_m) model_ovf = 1'b1;
            else if (ovf_clr) model_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", count, model_q.size());
            check("empty", empty, model_q.size() == 0);
            check("full", full, model_q.size() == 16);
            check("overflow", ovf, model_ovf);
            check("rd_valid", rd_valid, rd_expect.size() != 0);
            if (rd_expect.size() != 0) check("rd_data", rd_data, rd_expect.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_vld = 1'b1;
        rx_data = d;
        tick();
        rx_vld = 1'b0;
    endtask

    task automatic pop_one();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 8'h00);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_tmo"}, tmo, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; rx_vld = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
        rx_data = 8'h00; thresh = '0; tmo_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Two bytes in, two reads out, order checked by the scoreboard.
        push_byte(8'hA5);
        push_byte(8'h3C);
        pop_one();
        pop_one();
        tick();
        check("basic_empty", empty, 1);

        en = 1'b0;
        push_byte(8'h77);
        en = 1'b1;
        check("disabled_count", count, 0);
        check("disabled_ovf", ovf, 0);

        pop_one();
        check("empty_read_valid", rd_valid, 0);

        // Push into an empty FIFO while reading: the read is ignored.
        rx_vld = 1'b1; rx_data = 8'h5A; rd_req = 1'b1;
        tick();
        rx_vld = 1'b0; rd_req = 1'b0;
        check("push_on_empty_count", count, 1);
        check("push_on_empty_valid", rd_valid, 0);
        pop_one();
        tick();

        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        check("fill_ovf", ovf, 1);
        rx_vld = 1'b1; rx_data = 8'hFF; ovf_clr = 1'b1;
        tick();
        rx_vld = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_priority", ovf, 1);
        check("drop_count", count, 16);
        repeat (16) pop_one();
        tick();
        check("drain_empty", empty, 1);
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Full FIFO, push and pop together: new byte accepted, read last.
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        rx_vld = 1'b1; rx_data = 8'h99; rd_req = 1'b1;
        tick();
        rx_vld = 1'b0; rd_req = 1'b0;
        check("full_pushpop_count", count, 16);
        check("full_pushpop_ovf", ovf, 0);
        repeat (16) pop_one();
        tick();
        check("full_pushpop_empty", empty, 1);

        // Timeout 10: one cycle to leave IDLE, then ten counting cycles.
        tmo_cnt = 20'd10;
        push_byte(8'hC1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 10) check("tmo_early", tmo, 0);
            if (k == 11) begin
                check("tmo_set", tmo, 1);
                check("tmo_irq_lag", irq, 0);
            end
            if (k == 12) check("tmo_irq", irq, 1);
        end
        push_byte(8'hC2);
        check("tmo_push_no_exit", tmo, 1);
        pop_one();
        check("tmo_pop_exit", tmo, 0);
        check("tmo_irq_hold", irq, 1);
        pop_one();
        check("tmo_idle", tmo, 0);
        check("tmo_irq_clear", irq, 0);
        tick();
        tmo_cnt = '0;

        thresh = 5'd4;
        for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i));
        check("thr_count", count, 4);
        check("thr_irq_lag", irq, 0);
        tick();
        check("thr_irq_set", irq, 1);
        pop_one();
        tick();
        check("thr_irq_clear", irq, 0);
        thresh = '0;
        repeat (3) pop_one();
        tick();

        // Reset while a read result is visible and more requests are pending.
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        rd_req = 1'b1;
        tick();
        rx_vld = 1'b1; rx_data = 8'hEE;
        #1 rst = 1'b1;
        #1 check_reset("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_hold");
        rd_req = 1'b0; rx_vld = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", rd_valid, 0);
        check("post_rst_count", count, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
